nn_control: RTL and testbench
=============================

# nn_control

Training-sequence controller for the neural-network core. It drives the Pattern block's `TR`, `VL` and `SW` strobes and consumes its `TRAIN`, `VALID` and `EPOCH` counts. It also exchanges a go/ack handshake with Architecture for each sample. It counts misclassifications per validation pass and issues `SW` whenever an epoch beats the best error so far, so Pattern always holds the best weights.

## Interface
- `BITS`, 16, width of counts, counters and error totals
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a run; sampled in IDLE and DONE
- `TRAIN`  in  BITS  number of training samples per epoch (from Pattern)
- `VALID`  in  BITS  number of validation samples per epoch (from Pattern)
- `EPOCH`  in  BITS  number of epochs (from Pattern)
- `ack`  in  1  Architecture finished the current sample
- `err`  in  1  current validation sample misclassified; qualified by `go & ack`
- `TR`  out  1  fetch next training sample (to Pattern)
- `VL`  out  1  fetch next validation sample (to Pattern)
- `SW`  out  1  store weights (to Pattern)
- `go`  out  1  sample valid at Pattern outputs; Architecture processes it
- `learn`  out  1  1 = training sample (backprop enabled), 0 = validation
- `epoch`  out  BITS  index of the current epoch
- `best_err`  out  BITS  lowest validation error count so far
- `busy`  out  1  run in progress
- `done`  out  1  run complete
- `cfg_err`  out  1  run aborted because a count was zero

## Operation
States and transitions:
- **IDLE**
  - On `start`, latch `TRAIN`, `VALID` and `EPOCH`.
  - If any latched count is 0: go to DONE with `cfg_err` = 1.
  - Otherwise: go to T_LOAD and clear `epoch`, the sample counter and `err_cnt`; set `best_err` to all ones.
- **T_LOAD**
  - `TR` = 1 for one cycle, then go to T_RUN.
- **T_RUN**
  - `go` = 1 and `learn` = 1, held until `ack`.
  - On `ack`, increment the sample counter.
  - If the counter reaches `TRAIN`: clear it and go to V_LOAD. Otherwise go to T_LOAD.
- **V_LOAD**
  - `VL` = 1 for one cycle, then go to V_RUN.
- **V_RUN**
  - `go` = 1 and `learn` = 0 until `ack`.
  - On `ack`, add `err` to `err_cnt`; `err_cnt` saturates at all ones.
  - If the sample counter reaches `VALID`: go to EVAL. Otherwise go to V_LOAD.
- **EVAL**
  - If `err_cnt < best_err`: go to STORE.
  - Otherwise go to NEXT.
- **STORE**
  - `SW` = 1 for one cycle.
  - `best_err` <= `err_cnt`.
  - Go to NEXT.
- **NEXT**
  - Always: clear `err_cnt` and the sample counter.
  - If `epoch + 1 == EPOCH`: go to DONE.
  - Otherwise: increment `epoch` and go to T_LOAD.
- **DONE**
  - `done` = 1, `busy` = 0.
  - `start` begins a new run exactly as from IDLE, with `cfg_err` cleared first.

Rules:
- `TR`, `VL` and `SW` are mutually exclusive and never asserted together with `go`.
- Ties do not store: an equal error count does not trigger STORE, so earlier epochs win.
- The first completed epoch always stores, since `best_err` starts at all ones.
- `ack` outside T_RUN/V_RUN is ignored.
- `err` is ignored in T_RUN.
- `busy` is 1 in every state except IDLE and DONE.
- Config inputs are ignored while `busy` is 1.

## Timing
- Reset (asynchronous): state IDLE; all outputs 0 except `best_err`, which resets to all ones.
- Reset mid-run aborts immediately with no `SW`.
- Pattern registers its sample on the edge that ends a `TR`/`VL` cycle, so its data is valid throughout `go`.
- Per-sample cost is 1 load cycle plus N `go` cycles, where N ≥ 1 and the handshake completes on the first edge with `go & ack`.
- `go` drops in the cycle after the handshake.
- Epoch overhead is 2 cycles (EVAL, NEXT), plus 1 cycle when STORE is taken.
- `start` held high in DONE restarts a run on the next edge.

## Structure
- Package `nn_pkg` holds:
  - the `state_t` enum (IDLE, T_LOAD, T_RUN, V_LOAD, V_RUN, EVAL, STORE, NEXT, DONE);
  - the `BITS` default;
  - the `ERR_MAX` constant (all ones).
- Single module; no sub-module needed. The saturating error counter stays inline.

## Test plan
- **Minimal run.** Stimulus: `TRAIN`=2, `VALID`=1, `EPOCH`=1, `ack` tied high, `start` sampled at edge 0. Required:
  - `TR` high in cycles 1 and 3;
  - `VL` high in cycle 5;
  - `SW` high in cycle 8;
  - `done` first high in cycle 10.
- **Best-model tracking.** Stimulus: `TRAIN`=7, `VALID`=3, `EPOCH`=4, validation error counts per epoch 2, 3, 1, 1. Required: `SW` only in epochs 0 and 2; final `best_err` = 1.
- **Handshake stretch.** Stimulus: `ack` delayed 5 cycles. Required:
  - `go` held 6 cycles;
  - `TR`/`VL` stay low throughout;
  - `err` during T_RUN does not change `err_cnt`.
- **Zero config.** Stimulus: `VALID`=0, then `start`. Required:
  - `done` = 1 and `cfg_err` = 1 on the next cycle;
  - no `TR`, `VL`, `SW` or `go`.
- **Reset mid-V_RUN.** Stimulus: assert `rst` during V_RUN. Required:
  - all outputs 0 immediately, `best_err` = 0xFFFF;
  - a later `start` reruns cleanly from epoch 0.
- **Restart from DONE.** Stimulus: `start` in DONE with `EPOCH`=2. Required: a full new run, `cfg_err` = 0, `epoch` ends at 1.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and constants for the training-sequence controller
// Holds the controller state encoding, the default count width and the
// all-ones error value used to seed the best-error tracker.
package nn_pkg;

  localparam int BITS = 16;

  localparam logic [BITS-1:0] ERR_MAX = '1;

  typedef enum logic [3:0] {
    IDLE,
    T_LOAD,
    T_RUN,
    V_LOAD,
    V_RUN,
    EVAL,
    STORE,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/nn_control.sv
// rtl/nn_control.sv - training-sequence controller for the neural-network core
// Sequences epochs of training and validation samples through Pattern and
// Architecture, counts validation errors per epoch, and pulses SW whenever an
// epoch beats the best error so far.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  begin a run (honoured in IDLE and DONE only)
//   TRAIN, VALID, EPOCH    per-run counts from Pattern, latched on start
//   ack, err               Architecture handshake; err qualified by go & ack
//   TR, VL, SW             fetch-train / fetch-valid / store-weights strobes
//   go, learn              sample valid to Architecture; 1 = training sample
//   epoch, best_err        current epoch index, lowest error count so far
//   busy, done, cfg_err    run status; cfg_err = aborted on a zero count
module nn_control
  import nn_pkg::*;
#(
  parameter int BITS = nn_pkg::BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] TRAIN,
  input  logic [BITS-1:0] VALID,
  input  logic [BITS-1:0] EPOCH,
  input  logic            ack,
  input  logic            err,
  output logic            TR,
  output logic            VL,
  output logic            SW,
  output logic            go,
  output logic            learn,
  output logic [BITS-1:0] epoch,
  output logic [BITS-1:0] best_err,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  localparam logic [BITS-1:0] ALL_ONES = '1;
  localparam logic [BITS-1:0] ONE      = {{(BITS-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [BITS-1:0] train_n, valid_n, epochs_n;
  logic [BITS-1:0] cnt, err_cnt;
  logic            cfg_zero, cnt_hit, last_epoch;

  // Zero check uses the live inputs because they are latched on the same edge.
  assign cfg_zero   = (TRAIN == '0) || (VALID == '0) || (EPOCH == '0);
  // One shared sample counter; the limit depends on which phase is running.
  assign cnt_hit    = (cnt + ONE) == ((state == T_RUN) ? train_n : valid_n);
  assign last_epoch = (epoch + ONE) == epochs_n;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    TR        = 1'b0;
    VL        = 1'b0;
    SW        = 1'b0;
    go        = 1'b0;
    learn     = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = cfg_zero ? DONE : T_LOAD;
      T_LOAD: begin
        TR        = 1'b1;
        state_nxt = T_RUN;
      end
      T_RUN: begin
        go    = 1'b1;
        learn = 1'b1;
        if (ack) state_nxt = cnt_hit ? V_LOAD : T_LOAD;
      end
      V_LOAD: begin
        VL        = 1'b1;
        state_nxt = V_RUN;
      end
      V_RUN: begin
        go = 1'b1;
        if (ack) state_nxt = cnt_hit ? EVAL : V_LOAD;
      end
      // Strict compare: ties keep the earlier epoch's weights.
      EVAL:    state_nxt = (err_cnt < best_err) ? STORE : NEXT;
      STORE: begin
        SW        = 1'b1;
        state_nxt = NEXT;
      end
      NEXT:    state_nxt = last_epoch ? DONE : T_LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      train_n  <= '0;
      valid_n  <= '0;
      epochs_n <= '0;
      cnt      <= '0;
      err_cnt  <= '0;
      epoch    <= '0;
      best_err <= ALL_ONES;
      cfg_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            train_n  <= TRAIN;
            valid_n  <= VALID;
            epochs_n <= EPOCH;
            cfg_err  <= cfg_zero;
            if (!cfg_zero) begin
              epoch    <= '0;
              cnt      <= '0;
              err_cnt  <= '0;
              best_err <= ALL_ONES;
            end
          end
        end
        T_RUN: if (ack) cnt <= cnt_hit ? '0 : cnt + ONE;
        V_RUN: begin
          if (ack) begin
            cnt <= cnt + ONE;
            if (err && (err_cnt != ALL_ONES)) err_cnt <= err_cnt + ONE;
          end
        end
        STORE: best_err <= err_cnt;
        NEXT: begin
          err_cnt <= '0;
          cnt     <= '0;
          if (!last_epoch) epoch <= epoch + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_control.sv
// tb/tb_nn_control.sv - directed self-checking bench for nn_control
module tb_nn_control;

  logic        clk = 1'b0;
  logic        rst, start, ack, err;
  logic [15:0] TRAIN, VALID, EPOCH;
  logic        TR, VL, SW, go, learn, busy, done, cfg_err;
  logic [15:0] epoch, best_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nn_control #(.BITS(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .TRAIN(TRAIN), .VALID(VALID), .EPOCH(EPOCH),
    .ack(ack), .err(err),
    .TR(TR), .VL(VL), .SW(SW), .go(go), .learn(learn),
    .epoch(epoch), .best_err(best_err),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    logic       ack;
    logic [6:0] exp;   // {TR, VL, SW, go, learn, busy, done}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs until done (bounded), counting SW pulses and strobe-exclusivity violations.
  task automatic wait_done(input string name, input int max, output int sw_cnt, output int bad);
    int n;
    n = 0; sw_cnt = 0; bad = 0;
    while (!done && n < max) begin
      if (SW) sw_cnt++;
      if (int'(TR) + int'(VL) + int'(SW) + int'(go) > 1) bad++;
      step();
      n++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    vec_t tbl[10];
    int   errs[4];
    int   swc, bad, vidx, vp, gocnt, strb, n;
    logic [3:0] mask;

    rst = 1'b1; start = 1'b0; ack = 1'b0; err = 1'b0;
    TRAIN = 16'd0; VALID = 16'd0; EPOCH = 16'd0;
    step(); step();
    chk("reset_strobes", {TR, VL, SW, go, learn, busy, done}, 7'b0);
    chk("reset_best_err", best_err, 16'hFFFF);
    chk("reset_epoch", epoch, 0);
    chk("reset_cfg_err", cfg_err, 0);
    rst = 1'b0;
    step();

    // Minimal run: TRAIN=2 VALID=1 EPOCH=1, ack tied high.
    tbl[0] = '{1'b1, 7'b1000010};  // cycle 1  T_LOAD
    tbl[1] = '{1'b1, 7'b0001110};  // cycle 2  T_RUN
    tbl[2] = '{1'b1, 7'b1000010};  // cycle 3  T_LOAD
    tbl[3] = '{1'b1, 7'b0001110};  // cycle 4  T_RUN
    tbl[4] = '{1'b1, 7'b0100010};  // cycle 5  V_LOAD
    tbl[5] = '{1'b1, 7'b0001010};  // cycle 6  V_RUN
    tbl[6] = '{1'b1, 7'b0000010};  // cycle 7  EVAL
    tbl[7] = '{1'b1, 7'b0010010};  // cycle 8  STORE
    tbl[8] = '{1'b1, 7'b0000010};  // cycle 9  NEXT
    tbl[9] = '{1'b1, 7'b0000001};  // cycle 10 DONE
    TRAIN = 16'd2; VALID = 16'd1; EPOCH = 16'd1; ack = 1'b1; err = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ack = tbl[i].ack;
      chk($sformatf("min_cycle%0d", i + 1), {TR, VL, SW, go, learn, busy, done}, tbl[i].exp);
      step();
    end
    chk("min_best_err", best_err, 0);
    chk("min_epoch", epoch, 0);
    chk("min_cfg_err", cfg_err, 0);

    // Best-model tracking: errors per epoch 2,3,1,1 -> store in epochs 0 and 2.
    errs = '{2, 3, 1, 1};
    TRAIN = 16'd7; VALID = 16'd3; EPOCH = 16'd4; ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    swc = 0; bad = 0; vidx = 0; vp = 0; mask = 4'b0; n = 0;
    while (!done && n < 400) begin
      if (SW) begin
        swc++;
        if (vp > 0 && vp <= 4) mask[vp-1] = 1'b1;
      end
      if (int'(TR) + int'(VL) + int'(SW) + int'(go) > 1) bad++;
      if (go && !learn && vp < 4) begin
        err = (vidx < errs[vp]);
        vidx++;
        if (vidx == 3) begin
          vidx = 0;
          vp++;
        end
      end else begin
        err = 1'b0;
      end
      step();
      n++;
    end
    err = 1'b0;
    chk("best_done", done, 1);
    chk("best_sw_epochs", mask, 4'b0101);
    chk("best_sw_count", swc, 2);
    chk("best_best_err", best_err, 1);
    chk("best_epoch", epoch, 3);
    chk("best_exclusive", bad, 0);

    // Zero config from DONE.
    VALID = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_cfg_err", cfg_err, 1);
    chk("zero_strobes", {TR, VL, SW, go, busy}, 5'b0);
    strb = 0;
    for (int i = 0; i < 3; i++) begin
      strb += int'(TR | VL | SW | go);
      step();
    end
    chk("zero_quiet", strb, 0);

    // Restart from DONE with EPOCH=2; cfg_err must clear.
    TRAIN = 16'd1; VALID = 16'd1; EPOCH = 16'd2; ack = 1'b1; err = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_tr", TR, 1);
    chk("restart_cfg_err", cfg_err, 0);
    chk("restart_epoch0", epoch, 0);
    wait_done("restart_done", 100, swc, bad);
    chk("restart_epoch_end", epoch, 1);
    chk("restart_cfg_err_end", cfg_err, 0);
    chk("restart_sw_count", swc, 1);
    chk("restart_exclusive", bad, 0);

    // Handshake stretch: ack withheld 5 cycles, err high during T_RUN.
    TRAIN = 16'd1; VALID = 16'd1; EPOCH = 16'd1; ack = 1'b0; err = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hs_tr", TR, 1);
    gocnt = 0; strb = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      gocnt += int'(go);
      strb  += int'(TR | VL);
      ack = (i == 5);
      err = 1'b1;
    end
    step();
    ack = 1'b1; err = 1'b0;
    chk("hs_go_cycles", gocnt, 6);
    chk("hs_no_load", strb, 0);
    chk("hs_go_drop", go, 0);
    chk("hs_vl_next", VL, 1);
    wait_done("hs_done", 50, swc, bad);
    chk("hs_err_ignored", best_err, 0);

    // Reset mid-V_RUN, then clean rerun.
    TRAIN = 16'd1; VALID = 16'd2; EPOCH = 16'd2; ack = 1'b1; err = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(go && !learn) && n < 20) begin
      step();
      n++;
    end
    chk("rst_reached_vrun", go && !learn, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_strobes", {TR, VL, SW, go, learn, busy, done}, 7'b0);
    chk("rst_best_err", best_err, 16'hFFFF);
    chk("rst_epoch", epoch, 0);
    step();
    rst = 1'b0;
    step();
    chk("rst_idle_quiet", {TR, VL, SW, go, busy, done}, 6'b0);
    err = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rerun_tr", TR, 1);
    chk("rerun_epoch0", epoch, 0);
    wait_done("rerun_done", 100, swc, bad);
    chk("rerun_epoch_end", epoch, 1);
    chk("rerun_best_err", best_err, 0);
    chk("rerun_sw_count", swc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
